itof: RTL
=========

# itof

Pipelined signed 32-bit integer to IEEE-754 single-precision converter, the inverse of the `ftoi` path in the FPU. It accepts one integer per cycle with a valid strobe and produces the correctly rounded float three cycles later. Rounding is round-to-nearest-even. The block sits beside `ftoi` in the FPU and serves the int-to-float conversion instruction.

## Interface
- No parameters. Width is fixed at 32 in and 32 out.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `x`  in  32  two's-complement signed integer operand.
- `x_valid`  in  1  `x` is sampled on this edge.
- `y`  out  32  IEEE-754 single result: sign, 8-bit exponent, 23-bit fraction.
- `y_valid`  out  1  `y` holds a new result this cycle.

## Operation
- **Stage 1 (S1)**, registered:
  - sign `s = x[31]`.
  - magnitude `m = s ? -x : x`, taken as an unsigned 32-bit value, so -2^31 gives `m = 0x80000000`.
  - zero flag `z = (x == 0)`.
- **Stage 2 (S2)**, registered:
  - `lz` = leading-zero count of `m`, range 0..31. It is don't-care when `z`.
  - `n = m << lz`, so `n[31] = 1` when `m != 0`.
  - biased exponent `e = 158 - lz` (127 + 31 - lz), 8 bits.
- **Stage 3 (S3)**, registered to `y`:
  - fraction `f = n[30:8]`, guard `g = n[7]`, sticky `st = |n[6:0]`, lsb `l = n[8]`.
  - round-up `r = g & (st | l)`.
  - `{c, f'} = {1'b0, f} + r`, a 24-bit add.
  - If carry `c` is set: fraction = 0 and exponent = `e + 1`.
  - `y = {s, e', f'}`.
  - If `z`: `y = 32'h00000000`. Zero has no sign, so negative zero is never produced.
- Overflow and NaN/Inf are impossible. The maximum result is 2^31, exponent 158.
- Each stage carries a valid bit: S1 valid = `x_valid`, and each later valid is the previous stage's valid.
- `y` and `y_valid` update every cycle from S3. When the S3 valid bit is 0, `y` holds its previous value and `y_valid = 0`.
- There is no back-pressure and no stall. Throughput is one conversion per cycle, with any gap pattern on `x_valid` allowed.
- Datapath registers load unconditionally. Only the valid bits gate visibility.

## Timing
- Latency is exactly 3 cycles. If `x_valid` is high at edge N, then `y_valid` is high and `y` is the result after edge N+3.
- Back-to-back inputs on consecutive edges produce back-to-back outputs in the same order, with no bubbles.
- Reset values, after any rising edge with `rst = 1`:
  - `y = 0`, `y_valid = 0`, all internal valid bits = 0.
  - Datapath registers may also be cleared to 0.
- Reset mid-operation: every in-flight conversion is discarded. No `y_valid` pulse may appear for inputs sampled before or during reset.
  - If `rst` is high at edge N, an input with `x_valid` high at edge N is also dropped.
  - The first input accepted is the one at the first edge with `rst = 0`. Its result appears 3 edges later.
- `x_valid` held high during reset has no effect.
- Simultaneous events: `rst` takes priority over `x_valid` on the same edge.

## Test plan
- **Basic values**: x = 3, 0, -3, 2500, one per cycle, all valid → after 3 cycles, four consecutive `y_valid` with `y` = 0x40400000, 0x00000000, 0xC0400000, 0x451C4000.
- **Large value, exact drop**: x = 1000000001 → `y` = 0x4E6E6B28. The dropped bits are below guard, so the result rounds down.
- **Round-to-nearest-even**:
  - x = 16777217 (tie, even lsb) → 0x4B800000.
  - x = 16777219 (tie, odd lsb) → 0x4B800002.
  - x = 16777221 → 0x4B800002.
- **Extremes and mantissa carry-out**:
  - x = 0x7FFFFFFF → 0x4F000000 (rounds up with mantissa carry into the exponent).
  - x = 0x80000000 → 0xCF000000.
  - x = 1 → 0x3F800000.
  - x = -1 → 0xBF800000.
- **Valid gaps**:
  - `x_valid` pattern 1,0,1,1,0,1 with distinct x values → `y_valid` shows the same pattern delayed by 3 cycles.
  - `y` holds its last value on gap cycles.
- **Reset mid-flight**:
  - Issue three valid inputs, then assert `rst` for 1 cycle at the edge of the third → `y_valid` stays 0 for all three.
  - Input x = 5 at the first post-reset edge → `y` = 0x40A00000 exactly 3 cycles later.
- **Random sweep**: 10k random x values compared against a float reference model (`$shortrealtobits` / C cast) with latency 3. No mismatches are allowed.

Source files
------------

// File: rtl/itof.sv
// Signed 32-bit integer to IEEE-754 single converter, round-to-nearest-even.
// Four register ranks (S1, S2, S3, y), so a result appears three edges after its input is sampled.
module itof (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        x_valid,
  output logic [31:0] y,
  output logic        y_valid
);

  // S1: sign, magnitude, zero flag
  logic        v1;
  logic        s1;
  logic        z1;
  logic [31:0] m1;

  // S2: normalized magnitude (implicit one dropped), biased exponent
  logic        v2;
  logic        s2;
  logic        z2;
  logic [30:0] n2;
  logic [7:0]  e2;

  // S3: rounded and packed result
  logic        v3;
  logic [31:0] r3;

  logic [4:0]  lz;
  logic [30:0] n_shift;
  logic [7:0]  e_calc;

  logic [22:0] f;
  logic        g;
  logic        st;
  logic        l;
  logic        r;
  logic [23:0] f_sum;
  logic [7:0]  e_rnd;
  logic [22:0] f_rnd;
  logic [31:0] res;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      z1 <= 1'b0;
      m1 <= '0;
    end else begin
      v1 <= x_valid;
      s1 <= x[31];
      z1 <= (x == 32'd0);
      m1 <= x[31] ? (~x + 32'd1) : x;
    end
  end

  // Leading-zero count: the highest set bit wins because it is visited last.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (m1[i]) lz = 5'(31 - i);
    end
    n_shift = m1[30:0] << lz;
    e_calc  = 8'd158 - {3'b000, lz};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      s2 <= 1'b0;
      z2 <= 1'b0;
      n2 <= '0;
      e2 <= '0;
    end else begin
      v2 <= v1;
      s2 <= s1;
      z2 <= z1;
      n2 <= n_shift;
      e2 <= e_calc;
    end
  end

  // Round-to-nearest-even; a mantissa carry-out bumps the exponent.
  always_comb begin
    f     = n2[30:8];
    g     = n2[7];
    st    = |n2[6:0];
    l     = n2[8];
    r     = g & (st | l);
    f_sum = {1'b0, f} + {23'd0, r};
    if (f_sum[23]) begin
      f_rnd = 23'd0;
      e_rnd = e2 + 8'd1;
    end else begin
      f_rnd = f_sum[22:0];
      e_rnd = e2;
    end
    res = z2 ? 32'h0000_0000 : {s2, e_rnd, f_rnd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
      r3 <= '0;
    end else begin
      v3 <= v2;
      r3 <= res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= v3;
      if (v3) y <= r3;
    end
  end

endmodule
